ram_sp_sweep: RTL
=================

# ram_sp_sweep

Parametrised single-port synchronous RAM with a hardware initialisation sweep, a request/ready handshake and a registered read port with a valid strobe. It generalises the team's fixed 4-entry x 4-bit memory to arbitrary width and depth. It is the scratch or lookup store used by datapath blocks that need a known memory state after reset or after a software clear.

## Interface
Parameters:
- DATA_W, 4, word width in bits (>=1)
- ADDR_W, 2, address width in bits (>=1)
- DEPTH, 4, number of implemented words (1 .. 2**ADDR_W)
- INIT_VAL, 0, word written to every location by the sweep (DATA_W bits)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  request to re-run the init sweep (level, sampled on clk)
- req  in  1  access request
- we  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_W  word address
- din  in  DATA_W  write data
- ready  out  1  block accepts a request this cycle
- dout  out  DATA_W  registered read data; holds until the next completed read
- dout_valid  out  1  one-cycle strobe marking new dout
- init_done  out  1  high once a sweep has completed; low during a sweep

Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).

## Operation
- FSM states: SWEEP, IDLE.
- Reset (rst=1 at an edge):
  - state=SWEEP, sweep pointer ptr=0.
  - ready=0, init_done=0, dout=0, dout_valid=0.
  - Memory contents are not reset directly; the sweep overwrites them.
- SWEEP:
  - Each edge with rst=0 writes mem[ptr]=INIT_VAL and increments ptr.
  - The edge that writes ptr=DEPTH-1 moves to IDLE and sets ready=1 and init_done=1.
  - req, we, addr, din and clr are ignored throughout.
- IDLE:
  - ready=1.
  - A request is accepted at an edge with req=1 and ready=1.
  - Write (we=1): mem[addr]<=din at that edge.
  - Read (we=0): dout<=mem[addr] at that edge, and dout_valid=1 for exactly the following cycle.
  - Back-to-back accepts are allowed every cycle, giving one access per clock.
- clr in IDLE:
  - clr=1 at an edge moves to SWEEP with ptr=0 and clears ready and init_done.
  - A req at that same edge is dropped: no write, no read, dout_valid stays 0.
  - dout keeps its last value.
- Priority: rst > clr > req.
- Out-of-range address (addr >= DEPTH):
  - Write: accepted but ignored; memory is unchanged.
  - Read: accepted; dout=0 and dout_valid pulses as normal.
- dout changes only on an accepted read (or on rst). dout_valid is 0 in every other cycle.

## Timing
- Init latency: ready rises after DEPTH edges with rst=0 following reset or clr. The first request can be accepted on the next edge after that.
- Read latency: 1 cycle. Data and dout_valid are both visible in the cycle after the accepting edge.
- Write latency: 0 cycles. A read accepted on the edge after a write to the same address returns the new data.
- rst asserted mid-sweep or mid-access: the sweep restarts from ptr=0 and any pending dout_valid is cleared.
- ready is a pure function of state (IDLE). It does not depend on req, so there is no combinational path from req to ready.

## Test plan
- Reset sweep: DATA_W=4, DEPTH=4, INIT_VAL=4'hA, rst for 2 cycles -> ready=0 for exactly 4 cycles then 1; reads of addr 0..3 return 4'hA, each with a single dout_valid pulse 1 cycle after accept.
- Write then read: write 4'h6 to addr 2, then read addr 2 on the next edge -> dout=4'h6 with dout_valid one cycle later; reads of addr 0, 1 and 3 still return INIT_VAL; dout holds 4'h6 through 3 idle cycles with dout_valid=0.
- Back-to-back: DATA_W=8, DEPTH=16; write addr k=k*3 for k=0..15 on consecutive cycles, then read 0..15 on consecutive cycles -> 16 consecutive dout_valid pulses with the data in order.
- clr collision: in IDLE, assert clr and req (read addr 1) on the same edge -> no dout_valid; init_done drops; ready returns after DEPTH cycles; addr 1 reads INIT_VAL.
- Out of range: ADDR_W=3, DEPTH=5; write 8'hFF to addr 6, then read addr 6 -> dout=0 with dout_valid=1; reads of addr 0..4 are unchanged.
- Reset mid-sweep: assert rst on cycle 2 of a DEPTH=8 sweep -> ready stays 0 until 8 edges after rst deasserts; all 8 locations then read INIT_VAL.

Source files
------------

// File: rtl/ram_sp_sweep.sv
// Single-port synchronous RAM that fills itself with INIT_VAL after reset or clr,
// then serves one read or write per clock behind a req/ready handshake.
module ram_sp_sweep #(
  parameter int unsigned       DATA_W   = 4,
  parameter int unsigned       ADDR_W   = 2,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              init_done
);

  localparam int unsigned LAST = DEPTH - 1;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              ready_d;
  logic              init_done_d;
  logic              dout_valid_d;
  logic [DATA_W-1:0] dout_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              in_range_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses at or beyond DEPTH have no storage behind them.
  assign in_range_c = (32'(addr) < DEPTH);

  // Next-state, memory write port and registered-output next values.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    ready_d      = ready;
    init_done_d  = init_done;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = ptr;
    mem_wdata_c  = INIT_VAL;

    case (state)
      SWEEP: begin
        mem_we_c = 1'b1;
        if (32'(ptr) == LAST) begin
          state_d     = IDLE;
          ptr_d       = '0;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end else begin
          ptr_d = ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (clr) begin
          // clr wins over a same-edge request, which is dropped.
          state_d     = SWEEP;
          ptr_d       = '0;
          ready_d     = 1'b0;
          init_done_d = 1'b0;
        end else if (req) begin
          if (we) begin
            mem_we_c    = in_range_c;
            mem_addr_c  = addr;
            mem_wdata_c = din;
          end else begin
            dout_d       = in_range_c ? mem[addr] : '0;
            dout_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SWEEP;
      ptr        <= '0;
      ready      <= 1'b0;
      init_done  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      ready      <= ready_d;
      init_done  <= init_done_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
    end
  end

  // Storage is not reset; the sweep overwrites it.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

endmodule
